// File: rtl/coarse_cfo_est.sv
// rtl/coarse_cfo_est.sv - coarse MSK carrier-frequency-offset estimator
// Differential product, 4th power to strip the +-pi/2 MSK steps, block average, CORDIC angle.
module coarse_cfo_est #(
   parameter int IW          = 16,
   parameter int N_LOG2      = 8,
   parameter int FW          = 32,
   parameter int CORDIC_ITER = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          vld_in,
   input  logic [IW-1:0] i_in,
   input  logic [IW-1:0] q_in,
   output logic [FW-1:0] freq_word,
   output logic          done
);

   localparam int DPW = 2*IW + 1;
   localparam int DW  = IW + 1;
   localparam int PW  = IW + 2;
   localparam int MW  = 2*PW + 1;
   localparam int AW  = PW + N_LOG2;
   localparam int CW  = IW + 4;

   localparam logic signed [MW-1:0] PMAX = MW'((64'sd1 <<< (PW-1)) - 64'sd1);
   localparam logic signed [MW-1:0] PMIN = MW'(-(64'sd1 <<< (PW-1)));
   localparam logic [FW-1:0] POS_QUARTER = {2'b01, {(FW-2){1'b0}}};
   localparam logic [FW-1:0] NEG_QUARTER = {2'b11, {(FW-2){1'b0}}};

   // atan(2^-i) as a 32-bit binary angle; rescaled to FW below
   localparam logic [31:0] ATAN32 [0:31] = '{
      32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4,
      32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
      32'h0028BE53, 32'h00145F2E, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2F9, 32'h0000517C,
      32'h000028BE, 32'h0000145F, 32'h00000A2F, 32'h00000517,
      32'h0000028B, 32'h00000145, 32'h000000A2, 32'h00000051,
      32'h00000028, 32'h00000014, 32'h0000000A, 32'h00000005,
      32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
   };

   typedef enum logic [2:0] {S_IDLE, S_PRIME, S_ACCUM, S_CORDIC, S_OUT} state_t;

   state_t state, next_state;
   logic   prime, issue, accum, last_acc;

   logic signed [IW-1:0]  si, sq, pi, pq;
   logic signed [DPW-1:0] dp_re, dp_im;
   logic signed [DW-1:0]  d_re, d_im;
   logic signed [PW-1:0]  e_re, e_im, f_re, f_im;
   logic signed [MW-1:0]  dx, dy, ex, ey;
   logic                  d_vld, e_vld, f_vld;
   logic signed [AW-1:0]  acc_re, acc_im, sum_re, sum_im;
   logic [N_LOG2:0]       issue_cnt;
   logic [N_LOG2-1:0]     acc_cnt;
   logic signed [CW-1:0]  avg_x, avg_y, cx, cy, cx_sh, cy_sh;
   logic [FW-1:0]         cz, atan_step;
   logic [4:0]            iter;
   logic                  zero_vec;

   function automatic logic signed [PW-1:0] scale_sat(input logic signed [MW-1:0] v);
      logic signed [MW-1:0] s;
      logic signed [PW-1:0] r;
      s = v >>> (IW-1);
      if (s > PMAX)
         r = PW'(PMAX);
      else if (s < PMIN)
         r = PW'(PMIN);
      else
         r = PW'(s);
      return r;
   endfunction

   assign si = $signed(i_in);
   assign sq = $signed(q_in);

   // s_k * conj(s_prev)
   assign dp_re = DPW'(si) * DPW'(pi) + DPW'(sq) * DPW'(pq);
   assign dp_im = DPW'(sq) * DPW'(pi) - DPW'(si) * DPW'(pq);

   assign dx = MW'(d_re);
   assign dy = MW'(d_im);
   assign ex = MW'(e_re);
   assign ey = MW'(e_im);

   assign sum_re = acc_re + AW'(f_re);
   assign sum_im = acc_im + AW'(f_im);
   assign avg_x  = CW'(sum_re >>> N_LOG2);
   assign avg_y  = CW'(sum_im >>> N_LOG2);

   assign cx_sh     = cx >>> iter;
   assign cy_sh     = cy >>> iter;
   assign atan_step = FW'({ATAN32[iter], 32'b0} >> (64 - FW));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      prime      = 1'b0;
      issue      = 1'b0;
      accum      = 1'b0;
      last_acc   = 1'b0;
      case (state)
         S_IDLE: begin
            prime      = vld_in;
            next_state = vld_in ? S_ACCUM : S_PRIME;
         end
         S_PRIME: begin
            prime = vld_in;
            if (vld_in)
               next_state = S_ACCUM;
         end
         S_ACCUM: begin
            issue    = vld_in && !issue_cnt[N_LOG2];
            accum    = f_vld;
            last_acc = f_vld && (acc_cnt == '1);
            if (last_acc)
               next_state = S_CORDIC;
         end
         S_CORDIC: begin
            if (iter == 5'(CORDIC_ITER - 1))
               next_state = S_OUT;
         end
         S_OUT:   next_state = S_PRIME;
         default: next_state = S_IDLE;
      endcase
      if (!enable) begin
         next_state = S_IDLE;
         prime      = 1'b0;
         issue      = 1'b0;
         accum      = 1'b0;
         last_acc   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pi        <= '0;
         pq        <= '0;
         d_re      <= '0;
         d_im      <= '0;
         e_re      <= '0;
         e_im      <= '0;
         f_re      <= '0;
         f_im      <= '0;
         d_vld     <= 1'b0;
         e_vld     <= 1'b0;
         f_vld     <= 1'b0;
         acc_re    <= '0;
         acc_im    <= '0;
         issue_cnt <= '0;
         acc_cnt   <= '0;
         cx        <= '0;
         cy        <= '0;
         cz        <= '0;
         iter      <= '0;
         zero_vec  <= 1'b0;
         freq_word <= '0;
         done      <= 1'b0;
      end else begin
         done  <= 1'b0;
         d_vld <= issue;
         e_vld <= enable && d_vld;
         f_vld <= enable && e_vld;

         if (prime || issue) begin
            pi <= si;
            pq <= sq;
         end
         if (issue) begin
            d_re <= DW'(dp_re >>> IW);
            d_im <= DW'(dp_im >>> IW);
         end
         e_re <= scale_sat(dx*dx - dy*dy);
         e_im <= scale_sat((dx*dy) <<< 1);
         f_re <= scale_sat(ex*ex - ey*ey);
         f_im <= scale_sat((ex*ey) <<< 1);

         // abort or completed block: discard everything accumulated so far
         if (!enable || state == S_OUT) begin
            acc_re    <= '0;
            acc_im    <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
         end else begin
            if (issue)
               issue_cnt <= issue_cnt + 1'b1;
            if (accum) begin
               acc_re  <= sum_re;
               acc_im  <= sum_im;
               acc_cnt <= acc_cnt + 1'b1;
            end
         end

         // load the averaged vector already rotated into the right half-plane
         if (last_acc) begin
            iter     <= '0;
            zero_vec <= (avg_x == '0) && (avg_y == '0);
            if (!avg_x[CW-1]) begin
               cx <= avg_x;
               cy <= avg_y;
               cz <= '0;
            end else if (!avg_y[CW-1]) begin
               cx <= avg_y;
               cy <= -avg_x;
               cz <= POS_QUARTER;
            end else begin
               cx <= -avg_y;
               cy <= avg_x;
               cz <= NEG_QUARTER;
            end
         end else if (state == S_CORDIC && enable) begin
            iter <= iter + 1'b1;
            if (!cy[CW-1]) begin
               cx <= cx + cy_sh;
               cy <= cy - cx_sh;
               cz <= cz + atan_step;
            end else begin
               cx <= cx - cy_sh;
               cy <= cy + cx_sh;
               cz <= cz - atan_step;
            end
         end

         if (state == S_OUT && enable) begin
            freq_word <= zero_vec ? '0 : FW'($signed(cz) >>> 2);
            done      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_coarse_cfo_est.sv
// tb/tb_coarse_cfo_est.sv - scoreboard bench for coarse_cfo_est
module tb_coarse_cfo_est;

   localparam int IW     = 16;
   localparam int N_LOG2 = 8;
   localparam int FW     = 32;
   localparam int ITER   = 16;
   localparam int LAT    = ITER + 4;
   localparam int NSYM   = (1 << N_LOG2) + 1;

   localparam longint F1    = 64'sd42949673;
   localparam longint FA    = -64'sd429496730;
   localparam longint TOL0  = 64'sd429496;
   localparam longint TOL1  = 64'sd429497;
   localparam longint TOLA  = 64'sd2147484;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 enable = 1'b0;
   logic                 vld_in = 1'b0;
   logic signed [IW-1:0] i_in = '0;
   logic signed [IW-1:0] q_in = '0;
   logic signed [FW-1:0] freq_word;
   logic                 done;

   coarse_cfo_est #(
      .IW(IW), .N_LOG2(N_LOG2), .FW(FW), .CORDIC_ITER(ITER)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .vld_in(vld_in),
      .i_in(i_in), .q_in(q_in), .freq_word(freq_word), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint exp;
      longint tol;
      longint cyc;
   } sb_t;

   sb_t    sb_q[$];
   int     errors = 0;
   int     checks = 0;
   int     n_done = 0;
   longint cyc = 0;
   real    phase = 0.125;
   real    amp = 32000.0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
      checks++;
      if (obs > exp + tol || obs < exp - tol) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   always @(negedge clk) begin
      sb_t ent;
      if (done) begin
         n_done++;
         if (sb_q.size() == 0) begin
            check_val("unexpected_done", 1, 0, 0);
         end else begin
            ent = sb_q.pop_front();
            check_val("latency", cyc, ent.cyc, 0);
            check_val("freq_word", longint'(freq_word), ent.exp, ent.tol);
         end
      end
   end

   // one MSK symbol: +-quarter-cycle step plus the offset, returns the sampling edge
   task automatic send_sym(input real f_off, input int gap, output longint smp);
      real a;
      phase = phase + f_off + (($urandom_range(1) == 1) ? 0.25 : -0.25);
      phase = phase - $floor(phase);
      a = 6.283185307179586 * phase;
      i_in   = IW'($rtoi($floor(amp * $cos(a) + 0.5)));
      q_in   = IW'($rtoi($floor(amp * $sin(a) + 0.5)));
      vld_in = 1'b1;
      smp    = cyc + 1;
      @(posedge clk); #1;
      vld_in = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_burst(input real f_off, input int max_gap, input bit push,
                            input longint exp, input longint tol);
      longint smp;
      sb_t    ent;
      smp = 0;
      for (int k = 0; k < NSYM; k++)
         send_sym(f_off, int'($urandom_range(max_gap)), smp);
      if (push) begin
         ent.exp = exp;
         ent.tol = tol;
         ent.cyc = smp + LAT;
         sb_q.push_back(ent);
      end
   endtask

   task automatic wait_sb(input string tag);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check_val(tag, longint'(sb_q.size()), 0, 0);
      sb_q.delete();
   endtask

   initial begin
      longint smp;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("reset_freq", longint'(freq_word), 0, 0);
      check_val("reset_done", longint'(done), 0, 0);

      @(posedge clk); #1;
      for (int k = 0; k < 300; k++)
         send_sym(0.0, int'($urandom_range(2)), smp);
      repeat (30) begin
         @(posedge clk); #1;
      end
      check_val("idle_freq", longint'(freq_word), 0, 0);
      check_val("idle_dones", longint'(n_done), 0, 0);

      enable = 1'b1;
      run_burst(0.0, 0, 1'b1, 0, TOL0);
      wait_sb("timeout_zero");
      run_burst(0.01, 3, 1'b1, F1, TOL1);
      wait_sb("timeout_pos");
      run_burst(-0.01, 1, 1'b1, -F1, TOL1);
      wait_sb("timeout_neg");
      run_burst(0.15, 2, 1'b1, FA, TOLA);
      wait_sb("timeout_alias");

      for (int k = 0; k < 100; k++)
         send_sym(0.01, int'($urandom_range(2)), smp);
      enable = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check_val("hold_freq_idle", longint'(freq_word), FA, TOLA);
      enable = 1'b1;
      run_burst(-0.01, 2, 1'b1, -F1, TOL1);
      check_val("hold_freq_accum", longint'(freq_word), FA, TOLA);
      wait_sb("timeout_reenable");

      amp = 0.0;
      run_burst(0.01, 0, 1'b1, 0, 0);
      wait_sb("timeout_zero_vec");
      amp = 32000.0;
      run_burst(0.01, 1, 1'b1, F1, TOL1);
      wait_sb("timeout_pre_reset");

      run_burst(0.01, 0, 1'b0, 0, 0);
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_val("async_rst_freq", longint'(freq_word), 0, 0);
      check_val("async_rst_done", longint'(done), 0, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (60) begin
         @(posedge clk); #1;
      end
      check_val("post_rst_dones", longint'(n_done), 7, 0);
      check_val("post_rst_freq", longint'(freq_word), 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
